rx_buffer: RTL and testbench
============================

# rx_buffer

Receive-side data buffer for the serial peripheral, the counterpart of the transmit buffer. The receiver deserializer pushes completed bytes into a 4-entry circular FIFO; the host drains it through a 2-bit register address on a single-cycle read strobe. It reports ready, empty, full, overrun and underrun status to the host and the interrupt logic.

## Interface
- `BITWIDTH`, default 8: data byte width.
- `DEPTH`, default 4: FIFO entries. Must be a power of two; pointer width is log2(`DEPTH`).
- `rClk` input 1: clock; all state updates on the rising edge.
- `rRst` input 1: asynchronous, active-high reset.
- `rdataIn` input `BITWIDTH`: byte from the deserializer.
- `rWR` input 1: one-cycle push strobe from the deserializer.
- `rPERR` input 1: parity-error tag for `rdataIn`, sampled with `rWR`.
- `rRD` input 1: one-cycle host read strobe.
- `rpaddr` input 2: register select, sampled with `rRD`.
- `rdataOut` output `BITWIDTH`: registered read data.
- `rEMPTY` output 1: FIFO holds 0 entries.
- `rFULL` output 1: FIFO holds `DEPTH` entries.
- `rrxrdy` output 1: at least one byte available; this is the interrupt source.

## Operation
- State:
  - write pointer `wp`
  - read pointer `rp`
  - count `cnt`, width log2(`DEPTH`)+1, range 0..`DEPTH`
  - sticky flags `OVR` and `UNR`
  - storage `mem[DEPTH]`
- Both pointers wrap modulo `DEPTH`.
- Reset values:
  - `wp`, `rp`, `cnt`, `OVR`, `UNR` = 0
  - `rdataOut` = 0x00
  - `rEMPTY` = 1, `rFULL` = 0, `rrxrdy` = 0
  - `mem` is not reset.
- Register map on `rRD` (paddr):
  - 0 DATA: returns `mem[rp]` and pops (`rp`++, `cnt`--). If empty, returns 0x00, no pop, sets `UNR`.
  - 1 STATUS: returns {3'b0, PERR_HEAD, UNR, OVR, FULL, RXRDY}, i.e. bit0 ready, bit1 full, bit2 `OVR`, bit3 `UNR`, bit4 head parity error. Returns pre-clear values, then clears `OVR` and `UNR` on the same edge.
  - 2 COUNT: returns `cnt` zero-extended.
  - 3 PEEK: returns `mem[rp]` without popping. If empty, returns 0x00 and leaves `UNR` unchanged.
- Push (`rWR` = 1):
  - Not full: `mem[wp]` = `rdataIn`, `wp`++, `cnt`++.
  - Full with no simultaneous DATA pop: byte dropped, pointers unchanged, `OVR` set.
- Simultaneous push and DATA pop:
  - Both take effect and `cnt` is unchanged.
  - When full, the pop frees the slot and the push is accepted with no overrun.
  - When empty, the push is accepted, the pop is an underrun (0x00 returned, `UNR` set), and the new byte becomes the head.
- Flag set wins over STATUS clear on the same edge.
- `rRD` with no `rWR` never modifies `mem`.
- Outputs are combinational from registered state: `rEMPTY` = (`cnt`==0), `rFULL` = (`cnt`==`DEPTH`), `rrxrdy` = !`rEMPTY`.

## Timing
- `rdataOut` is valid the cycle after the edge that samples `rRD`. It holds until the next `rRD`.
- Push-to-visible latency is 1 edge:
  - A byte pushed at edge N raises `rrxrdy` after N.
  - It is readable by an `rRD` sampled at edge N+1.
  - There is no same-edge fall-through.
- Back-to-back `rRD` on consecutive cycles is supported at one pop per cycle.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge. Buffered bytes are lost. The first edge after deassertion behaves as post-reset.

## Configuration
- `RX_BUF_PARITY_EN` defined:
  - `mem` entries are `BITWIDTH`+1 bits and store `rPERR` alongside the data.
  - STATUS bit4 = stored tag of the head entry; it reads 0 when empty.
- `RX_BUF_PARITY_EN` undefined:
  - `rPERR` is ignored and entries are `BITWIDTH` bits.
  - STATUS bit4 reads 0.

## Structure
- `rx_buffer_pkg` holds:
  - `BITWIDTH` and `DEPTH` defaults
  - register address constants `RX_ADDR_DATA`=0, `RX_ADDR_STAT`=1, `RX_ADDR_CNT`=2, `RX_ADDR_PEEK`=3
  - STATUS bit index constants
- One sub-module, `rx_fifo_core`, contains the storage, pointers, count and full/empty logic.
- `rx_buffer` contains the register decode, sticky flags and the `rdataOut` register.

## Test plan
- Reset, then push 0xA5, then DATA read → `rrxrdy` goes 1 the cycle after the push; `rdataOut`=0xA5 the cycle after `rRD`; `rEMPTY` returns to 1.
- Push 0x11, 0x22, 0x33, 0x44, then push 0x55 → `rFULL`=1 and STATUS=0x07; four DATA reads return 0x11, 0x22, 0x33, 0x44 (0x55 was dropped); a second STATUS read returns 0x00 because `OVR` was cleared.
- Full FIFO with same-edge push of 0x66 and DATA pop → head 0x11 is returned, `cnt` stays 4, `OVR` stays 0, and the last entry drained is 0x66.
- DATA read on empty → `rdataOut`=0x00 and STATUS bit3=1. PEEK on empty → 0x00 and `UNR` unchanged.
- Push 3 bytes, assert `rRst` between clock edges → all outputs take their reset values immediately; COUNT reads 0 after release.
- With `RX_BUF_PARITY_EN`, push 0x7E with `rPERR`=1 → STATUS=0x11 (PERR_HEAD and RXRDY); after the pop, bit4 = 0.

Source files
------------

// File: rtl/rx_buffer_pkg.sv
// Shared constants for the receive buffer: default sizes, register map, STATUS bit layout.
// Latency: n/a (constants only).
// Backpressure: n/a. Optional parity tagging is enabled by defining RX_BUF_PARITY_EN.
package rx_buffer_pkg;

  localparam int RX_BITWIDTH_DEF = 8;
  localparam int RX_DEPTH_DEF    = 4;

  // Host register addresses, sampled with the read strobe
  localparam logic [1:0] RX_ADDR_DATA = 2'd0;
  localparam logic [1:0] RX_ADDR_STAT = 2'd1;
  localparam logic [1:0] RX_ADDR_CNT  = 2'd2;
  localparam logic [1:0] RX_ADDR_PEEK = 2'd3;

  // STATUS register bit positions
  localparam int RX_STAT_RXRDY = 0;
  localparam int RX_STAT_FULL  = 1;
  localparam int RX_STAT_OVR   = 2;
  localparam int RX_STAT_UNR   = 3;
  localparam int RX_STAT_PERR  = 4;

endpackage

// File: rtl/rx_fifo_core.sv
// Circular FIFO storage with pointers, occupancy count and full/empty flags.
// Latency: push visible at head one edge later; head is read combinationally.
// Backpressure: push into a full FIFO is dropped unless a pop frees the slot on the same edge.
module rx_fifo_core #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH):0]     cnt_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pop_eff;
  logic          push_acc;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign cnt_o   = cnt_q;
  assign head_o  = mem[rp_q];

  // A pop on an empty FIFO does nothing; a same-edge pop lets a push into a full FIFO through.
  assign pop_eff  = pop_i && !empty_o;
  assign push_acc = push_i && (!full_o || pop_eff);

  // Next-state for pointers and occupancy; power-of-two depth makes pointer wrap free.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push_acc) wp_d = wp_q + PW'(1);
    if (pop_eff)  rp_d = rp_q + PW'(1);
    case ({push_acc, pop_eff})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (push_acc) mem[wp_q] <= wdata_i;
  end

endmodule

// File: rtl/rx_buffer.sv
// Receive buffer: FIFO of deserialized bytes drained by the host via a 2-bit register map.
// Latency: read data registered, valid the cycle after the read strobe; push visible after 1 edge.
// Backpressure: none; full-drop sets sticky OVR, empty DATA read sets sticky UNR. Option: RX_BUF_PARITY_EN.
module rx_buffer
  import rx_buffer_pkg::*;
#(
  parameter int BITWIDTH = RX_BITWIDTH_DEF,
  parameter int DEPTH    = RX_DEPTH_DEF
) (
  input  logic                rClk,
  input  logic                rRst,
  input  logic [BITWIDTH-1:0] rdataIn,
  input  logic                rWR,
  input  logic                rPERR,
  input  logic                rRD,
  input  logic [1:0]          rpaddr,
  output logic [BITWIDTH-1:0] rdataOut,
  output logic                rEMPTY,
  output logic                rFULL,
  output logic                rrxrdy
);

  localparam int CW = $clog2(DEPTH) + 1;

`ifdef RX_BUF_PARITY_EN
  localparam int EW = BITWIDTH + 1;
`else
  localparam int EW = BITWIDTH;
`endif

  logic [EW-1:0]       wentry;
  logic [EW-1:0]       head;
  logic [CW-1:0]       cnt;
  logic                empty;
  logic                full;
  logic                perr_head;
  logic                data_rd;
  logic                stat_rd;
  logic                ovr_set;
  logic                unr_set;
  logic                ovr_q, ovr_d;
  logic                unr_q, unr_d;
  logic [BITWIDTH-1:0] status;
  logic [BITWIDTH-1:0] head_dat;
  logic [BITWIDTH-1:0] rdata_q, rdata_d;

`ifdef RX_BUF_PARITY_EN
  assign wentry    = {rPERR, rdataIn};
  assign perr_head = !empty && head[BITWIDTH];
`else
  logic unused_perr;
  assign unused_perr = rPERR;
  assign wentry      = rdataIn;
  assign perr_head   = 1'b0;
`endif

  assign head_dat = head[BITWIDTH-1:0];
  assign data_rd  = rRD && (rpaddr == RX_ADDR_DATA);
  assign stat_rd  = rRD && (rpaddr == RX_ADDR_STAT);
  // Full implies non-empty, so any DATA read frees a slot for the incoming byte.
  assign ovr_set  = rWR && full && !data_rd;
  assign unr_set  = data_rd && empty;

  rx_fifo_core #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (rClk),
    .rst_i   (rRst),
    .push_i  (rWR),
    .pop_i   (data_rd),
    .wdata_i (wentry),
    .head_o  (head),
    .cnt_o   (cnt),
    .empty_o (empty),
    .full_o  (full)
  );

  assign rEMPTY   = empty;
  assign rFULL    = full;
  assign rrxrdy   = !empty;
  assign rdataOut = rdata_q;

  // STATUS word assembled from pre-clear flag values.
  always_comb begin
    status                = '0;
    status[RX_STAT_RXRDY] = !empty;
    status[RX_STAT_FULL]  = full;
    status[RX_STAT_OVR]   = ovr_q;
    status[RX_STAT_UNR]   = unr_q;
    status[RX_STAT_PERR]  = perr_head;
  end

  // Register read mux; read data holds between strobes. Flag sets win over STATUS clear.
  always_comb begin
    rdata_d = rdata_q;
    ovr_d   = (stat_rd ? 1'b0 : ovr_q) | ovr_set;
    unr_d   = (stat_rd ? 1'b0 : unr_q) | unr_set;
    if (rRD) begin
      case (rpaddr)
        RX_ADDR_DATA: rdata_d = empty ? '0 : head_dat;
        RX_ADDR_STAT: rdata_d = status;
        RX_ADDR_CNT:  rdata_d = BITWIDTH'(cnt);
        default:      rdata_d = empty ? '0 : head_dat;
      endcase
    end
  end

  // Read data and sticky flag registers, cleared asynchronously.
  always_ff @(posedge rClk or posedge rRst) begin
    if (rRst) begin
      rdata_q <= '0;
      ovr_q   <= 1'b0;
      unr_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      ovr_q   <= ovr_d;
      unr_q   <= unr_d;
    end
  end

endmodule

// File: tb/tb_rx_buffer.sv
// Self-checking bench for rx_buffer against a queue-based reference model.
// Latency: inputs applied after each edge, outputs sampled 1 time unit after the next edge.
// Backpressure: n/a. Parity scenario runs only when RX_BUF_PARITY_EN is defined.
module tb_rx_buffer;

  localparam int DEPTH = 4;
`ifdef RX_BUF_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       rClk = 1'b0;
  logic       rRst = 1'b1;
  logic [7:0] rdataIn = '0;
  logic       rWR = 1'b0;
  logic       rPERR = 1'b0;
  logic       rRD = 1'b0;
  logic [1:0] rpaddr = '0;
  logic [7:0] rdataOut;
  logic       rEMPTY;
  logic       rFULL;
  logic       rrxrdy;

  int checks = 0;
  int failures = 0;

  // reference model: queue of {perr, data}, sticky flags, expected read data
  logic [8:0] q[$];
  bit         m_ovr;
  bit         m_unr;
  logic [7:0] exp_dout;

  rx_buffer dut (
    .rClk     (rClk),
    .rRst     (rRst),
    .rdataIn  (rdataIn),
    .rWR      (rWR),
    .rPERR    (rPERR),
    .rRD      (rRD),
    .rpaddr   (rpaddr),
    .rdataOut (rdataOut),
    .rEMPTY   (rEMPTY),
    .rFULL    (rFULL),
    .rrxrdy   (rrxrdy)
  );

  always #5 rClk = ~rClk;

  task automatic model_reset();
    q.delete();
    m_ovr    = 1'b0;
    m_unr    = 1'b0;
    exp_dout = 8'h00;
  endtask

  task automatic model_step(input bit wr, input logic [7:0] din, input bit perr,
                            input bit rd, input logic [1:0] addr);
    int         n;
    bit         pop;
    bit         ovr_set;
    bit         unr_set;
    logic [7:0] st;
    n       = q.size();
    ovr_set = 1'b0;
    unr_set = 1'b0;
    if (rd) begin
      case (addr)
        2'd0, 2'd3: exp_dout = (n > 0) ? q[0][7:0] : 8'h00;
        2'd1: begin
          st       = 8'h00;
          st[0]    = (n > 0);
          st[1]    = (n == DEPTH);
          st[2]    = m_ovr;
          st[3]    = m_unr;
          st[4]    = PAR && (n > 0) && q[0][8];
          exp_dout = st;
        end
        default: exp_dout = n[7:0];
      endcase
    end
    pop     = rd && (addr == 2'd0) && (n > 0);
    unr_set = rd && (addr == 2'd0) && (n == 0);
    if (pop) void'(q.pop_front());
    if (wr) begin
      if (n < DEPTH || pop) q.push_back({perr, din});
      else ovr_set = 1'b1;
    end
    if (rd && addr == 2'd1) begin
      m_ovr = 1'b0;
      m_unr = 1'b0;
    end
    m_ovr = m_ovr | ovr_set;
    m_unr = m_unr | unr_set;
  endtask

  // one clock cycle of stimulus; returns 1 time unit after the edge with strobes dropped
  task automatic drive(input bit wr, input logic [7:0] din, input bit perr,
                       input bit rd, input logic [1:0] addr);
    rWR     = wr;
    rdataIn = din;
    rPERR   = perr;
    rRD     = rd;
    rpaddr  = addr;
    @(posedge rClk);
    model_step(wr, din, perr, rd, addr);
    #1;
    rWR   = 1'b0;
    rRD   = 1'b0;
    rPERR = 1'b0;
  endtask

  task automatic do_reset();
    rRst = 1'b1;
    #3;
    rRst = 1'b0;
    model_reset();
    @(posedge rClk);
    #1;
  endtask

  task automatic test_reset();
    rRst = 1'b1;
    #3;
    checks++;
    if ({rdataOut, rEMPTY, rFULL, rrxrdy} !== {8'h00, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs got dout=%h empty=%b full=%b rdy=%b want 00/1/0/0",
               rdataOut, rEMPTY, rFULL, rrxrdy);
    end
    rRst = 1'b0;
    model_reset();
    @(posedge rClk);
    #1;
  endtask

  task automatic test_basic();
    drive(1, 8'hA5, 0, 0, 2'd0);
    checks++;
    if (rrxrdy !== 1'b1) begin
      failures++;
      $display("FAIL basic_rdy got %b want 1", rrxrdy);
    end
    drive(0, 8'h00, 0, 1, 2'd0);
    checks++;
    if (rdataOut !== 8'hA5) begin
      failures++;
      $display("FAIL basic_data got %h want a5", rdataOut);
    end
    checks++;
    if (rEMPTY !== 1'b1) begin
      failures++;
      $display("FAIL basic_empty got %b want 1", rEMPTY);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] want;
    drive(1, 8'h11, 0, 0, 2'd0);
    drive(1, 8'h22, 0, 0, 2'd0);
    drive(1, 8'h33, 0, 0, 2'd0);
    drive(1, 8'h44, 0, 0, 2'd0);
    drive(1, 8'h55, 0, 0, 2'd0);
    checks++;
    if (rFULL !== 1'b1) begin
      failures++;
      $display("FAIL ovr_full got %b want 1", rFULL);
    end
    drive(0, 8'h00, 0, 1, 2'd1);
    checks++;
    if (rdataOut !== 8'h07) begin
      failures++;
      $display("FAIL ovr_status got %h want 07", rdataOut);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 8'h00, 0, 1, 2'd0);
      want = 8'h11 * (i + 1);
      checks++;
      if (rdataOut !== want) begin
        failures++;
        $display("FAIL ovr_drain%0d got %h want %h", i, rdataOut, want);
      end
    end
    drive(0, 8'h00, 0, 1, 2'd1);
    checks++;
    if (rdataOut !== 8'h00) begin
      failures++;
      $display("FAIL ovr_status_cleared got %h want 00", rdataOut);
    end
  endtask

  task automatic test_simul_full();
    drive(1, 8'h11, 0, 0, 2'd0);
    drive(1, 8'h22, 0, 0, 2'd0);
    drive(1, 8'h33, 0, 0, 2'd0);
    drive(1, 8'h44, 0, 0, 2'd0);
    drive(1, 8'h66, 0, 1, 2'd0);
    checks++;
    if (rdataOut !== 8'h11) begin
      failures++;
      $display("FAIL simul_head got %h want 11", rdataOut);
    end
    drive(0, 8'h00, 0, 1, 2'd2);
    checks++;
    if (rdataOut !== 8'h04) begin
      failures++;
      $display("FAIL simul_count got %h want 04", rdataOut);
    end
    drive(0, 8'h00, 0, 1, 2'd1);
    checks++;
    if (rdataOut !== 8'h03) begin
      failures++;
      $display("FAIL simul_status got %h want 03", rdataOut);
    end
    for (int i = 0; i < 4; i++) drive(0, 8'h00, 0, 1, 2'd0);
    checks++;
    if (rdataOut !== 8'h66) begin
      failures++;
      $display("FAIL simul_last got %h want 66", rdataOut);
    end
  endtask

  task automatic test_underrun_peek();
    drive(0, 8'h00, 0, 1, 2'd0);
    checks++;
    if (rdataOut !== 8'h00) begin
      failures++;
      $display("FAIL unr_data got %h want 00", rdataOut);
    end
    drive(0, 8'h00, 0, 1, 2'd3);
    checks++;
    if (rdataOut !== 8'h00) begin
      failures++;
      $display("FAIL peek_empty got %h want 00", rdataOut);
    end
    drive(0, 8'h00, 0, 1, 2'd1);
    checks++;
    if (rdataOut !== 8'h08) begin
      failures++;
      $display("FAIL unr_status got %h want 08", rdataOut);
    end
    drive(0, 8'h00, 0, 1, 2'd3);
    drive(0, 8'h00, 0, 1, 2'd1);
    checks++;
    if (rdataOut[3] !== 1'b0) begin
      failures++;
      $display("FAIL peek_no_unr got %b want 0", rdataOut[3]);
    end
  endtask

  task automatic test_async_reset();
    drive(1, 8'h01, 0, 0, 2'd0);
    drive(1, 8'h02, 0, 0, 2'd0);
    drive(1, 8'h03, 0, 0, 2'd0);
    drive(0, 8'h00, 0, 1, 2'd2);
    checks++;
    if (rdataOut !== 8'h03) begin
      failures++;
      $display("FAIL arst_pre_count got %h want 03", rdataOut);
    end
    #2;
    rRst = 1'b1;
    #1;
    checks++;
    if ({rdataOut, rEMPTY, rFULL, rrxrdy} !== {8'h00, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL arst_outputs got dout=%h empty=%b full=%b rdy=%b want 00/1/0/0",
               rdataOut, rEMPTY, rFULL, rrxrdy);
    end
    #2;
    rRst = 1'b0;
    model_reset();
    drive(0, 8'h00, 0, 1, 2'd2);
    checks++;
    if (rdataOut !== 8'h00) begin
      failures++;
      $display("FAIL arst_count got %h want 00", rdataOut);
    end
  endtask

`ifdef RX_BUF_PARITY_EN
  task automatic test_parity();
    drive(1, 8'h7E, 1, 0, 2'd0);
    drive(0, 8'h00, 0, 1, 2'd1);
    checks++;
    if (rdataOut !== 8'h11) begin
      failures++;
      $display("FAIL par_status got %h want 11", rdataOut);
    end
    drive(0, 8'h00, 0, 1, 2'd0);
    checks++;
    if (rdataOut !== 8'h7E) begin
      failures++;
      $display("FAIL par_data got %h want 7e", rdataOut);
    end
    drive(0, 8'h00, 0, 1, 2'd1);
    checks++;
    if (rdataOut[4] !== 1'b0) begin
      failures++;
      $display("FAIL par_bit4_after_pop got %b want 0", rdataOut[4]);
    end
  endtask
`endif

  task automatic test_random();
    bit         wr;
    bit         rd;
    bit         perr;
    logic [7:0] din;
    logic [1:0] addr;
    int         n;
    for (int i = 0; i < 600; i++) begin
      wr   = ($urandom_range(0, 99) < 55);
      rd   = ($urandom_range(0, 99) < 50);
      perr = $urandom_range(0, 1) == 1;
      din  = 8'($urandom);
      addr = 2'($urandom_range(0, 3));
      drive(wr, din, perr, rd, addr);
      n = q.size();
      checks++;
      if (rdataOut !== exp_dout) begin
        failures++;
        $display("FAIL rand_dout cyc=%0d got %h want %h", i, rdataOut, exp_dout);
      end
      checks++;
      if ({rEMPTY, rFULL, rrxrdy} !== {n == 0, n == DEPTH, n > 0}) begin
        failures++;
        $display("FAIL rand_flags cyc=%0d got e/f/r=%b%b%b want count %0d",
                 i, rEMPTY, rFULL, rrxrdy, n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    do_reset();
    test_simul_full();
    do_reset();
    test_underrun_peek();
    test_async_reset();
`ifdef RX_BUF_PARITY_EN
    do_reset();
    test_parity();
`endif
    do_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
